// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, shifts a
// command byte plus odd parity out on the device clock and checks the device acknowledge.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_error
);

    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INHIBIT_END  = CNT_W'(INHIBIT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [3:0]       bit_cnt;
    logic [3:0]       bit_cnt_next;
    logic [8:0]       frame;
    logic [8:0]       frame_next;
    logic             data_drive;
    logic             data_drive_next;
    logic             ack_seen;
    logic             ack_seen_next;
    logic             done_next;
    logic             ack_ok_next;
    logic             error_next;

    logic clk_meta;
    logic clk_sync;
    logic clk_prev;
    logic data_meta;
    logic data_sync;
    logic dev_fall;

    // Synchronizers come out of reset at the idle (released, high) line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign dev_fall = clk_prev & ~clk_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            data_drive <= 1'b0;
            ack_seen   <= 1'b0;
            tx_done    <= 1'b0;
            tx_ack_ok  <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_cnt    <= bit_cnt_next;
            frame      <= frame_next;
            data_drive <= data_drive_next;
            ack_seen   <= ack_seen_next;
            tx_done    <= done_next;
            tx_ack_ok  <= ack_ok_next;
            tx_error   <= error_next;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        bit_cnt_next    = bit_cnt;
        frame_next      = frame;
        data_drive_next = data_drive;
        ack_seen_next   = ack_seen;
        done_next       = 1'b0;
        ack_ok_next     = tx_ack_ok;
        error_next      = tx_error;

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    frame_next      = {~^tx_byte, tx_byte};
                    cnt_next        = '0;
                    bit_cnt_next    = '0;
                    data_drive_next = 1'b0;
                    ack_seen_next   = 1'b0;
                    state_next      = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INHIBIT_END) begin
                    cnt_next   = '0;
                    state_next = RTS;
                end else begin
                    cnt_next = cnt + 1'b1;
                    if (cnt == INHIBIT_LAST) begin
                        data_drive_next = 1'b1;
                    end
                end
            end
            RTS: begin
                if (dev_fall) begin
                    data_drive_next = ~frame[0];
                    frame_next      = {1'b0, frame[8:1]};
                    bit_cnt_next    = 4'd1;
                    state_next      = SHIFT;
                end
            end
            SHIFT: begin
                // Edges 2..9 put out the remaining data bits and parity; edge 10 is the stop bit.
                if (dev_fall) begin
                    if (bit_cnt == 4'd9) begin
                        data_drive_next = 1'b0;
                        state_next      = ACK;
                    end else begin
                        data_drive_next = ~frame[0];
                        frame_next      = {1'b0, frame[8:1]};
                        bit_cnt_next    = bit_cnt + 1'b1;
                    end
                end
            end
            ACK: begin
                if (dev_fall) begin
                    ack_seen_next = ~data_sync;
                    state_next    = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_next   = 1'b1;
                    ack_ok_next = ack_seen;
                    error_next  = ~ack_seen;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Once the device owns the clock, every gap between falling edges is bounded.
        if (state inside {RTS, SHIFT, ACK, WAIT_IDLE}) begin
            if (dev_fall) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt + 1'b1;
                if (cnt == TIMEOUT_LAST && state_next != IDLE) begin
                    data_drive_next = 1'b0;
                    done_next       = 1'b1;
                    ack_ok_next     = 1'b0;
                    error_next      = 1'b1;
                    state_next      = IDLE;
                end
            end
        end

        if (state_next == IDLE) begin
            cnt_next     = '0;
            bit_cnt_next = '0;
        end
    end

    assign ps2_clk_drive_low  = (state == INHIBIT);
    assign ps2_data_drive_low = data_drive;
    assign tx_ready           = (state == IDLE);

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 2500, giving the clk cycles the PS/2 clock line is held low before request-to-send (100 us at 25 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 500000, giving the maximum clk cycles allowed between consecutive device-clock falling edges (20 ms at 25 MHz).
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous to clk, active-low.
REQ-005 ps2_clk_in  input  1  sampled PS/2 clock line; asynchronous to clk.
REQ-006 ps2_data_in  input  1  sampled PS/2 data line; asynchronous to clk.
REQ-007 ps2_clk_drive_low  output  1  1 = pull PS/2 clock low (open-drain); 0 = release.
REQ-008 ps2_data_drive_low  output  1  1 = pull PS/2 data low (open-drain); 0 = release.
REQ-009 tx_byte  input  8  command byte to send to the keyboard.
REQ-010 tx_valid  input  1  request to send tx_byte.
REQ-011 tx_ready  output  1  high only in IDLE; a byte is accepted when tx_valid and tx_ready are both high.
REQ-012 tx_done  output  1  one-cycle pulse at transfer end, success or failure.
REQ-013 tx_ack_ok  output  1  registered with tx_done; 1 = device acknowledged; holds until the next tx_done.
REQ-014 tx_error  output  1  registered with tx_done; 1 = timeout or missing acknowledge; holds until the next tx_done.

Function
REQ-015 ps2_clk_in and ps2_data_in SHALL each pass through a 2-flop synchronizer; a device falling edge is sync_prev=1 and sync_now=0 on the synchronized clock.
REQ-016 States SHALL be IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
REQ-017 On acceptance, the block SHALL latch tx_byte, compute odd parity (parity bit = ~^tx_byte), and enter INHIBIT.
REQ-018 INHIBIT: clk_drive_low=1 and data_drive_low=0 for INHIBIT_CYCLES cycles, then data_drive_low=1 for 1 further cycle, then enter RTS.
REQ-019 RTS: clk_drive_low=0 and data_drive_low=1 (start bit); the timeout counter starts.
REQ-020 Device falling edges 1..8 SHALL set data_drive_low=~D[k-1], LSB first, on the cycle after the edge is detected; edge 9 SHALL drive the parity bit; edge 10 SHALL release data (stop bit) and enter ACK.
REQ-021 In ACK, on the next falling edge: sampled data 0 -> ack_ok=1, else error=1; then enter WAIT_IDLE.
REQ-022 WAIT_IDLE SHALL wait until both synchronized lines are 1, then pulse tx_done and return to IDLE.
REQ-023 The timeout counter SHALL reset on each falling edge; reaching TIMEOUT_CYCLES in RTS, SHIFT or ACK SHALL release both lines, set error=1 and ack_ok=0, pulse tx_done, and return to IDLE. WAIT_IDLE SHALL also be bounded by TIMEOUT_CYCLES and is handled the same way on expiry.
REQ-024 tx_valid outside IDLE SHALL be ignored; tx_byte changes after acceptance SHALL not affect the transfer.
REQ-025 A falling edge seen in IDLE or INHIBIT SHALL be ignored (the device's own transmit is overridden by inhibit).
REQ-026 Counter widths SHALL be $clog2 of the largest parameter plus 1; there SHALL be no wrap before the terminal count.

Reset
REQ-027 When rst_n=0 at a clk edge, the block SHALL enter IDLE with both drive_low=0, tx_ready=1, tx_done=0, tx_ack_ok=0, tx_error=0, and all counters at 0, including mid-transfer (the lines are released on the next clock).

Verification
REQ-028 Send 0xED with a device model ACKing -> data_drive_low sequence after the start bit: 0,1,0,0,1,0,0,0, parity 0 (drives 1,0,1,1,0,1,1,1 and parity 1 on the line); tx_done pulse with ack_ok=1, error=0.
REQ-029 Send 0xF4 -> parity bit on the line is 0 (data_drive_low=1 at edge 9); ACK gives ack_ok=1.
REQ-030 Device never clocks after RTS -> after INHIBIT_CYCLES+1+TIMEOUT_CYCLES cycles: tx_done, error=1, both lines released, tx_ready=1.
REQ-031 Device holds data high at edge 11 -> tx_done with ack_ok=0, error=1.
REQ-032 Assert rst_n=0 at edge 5 of a transfer -> next cycle both drive_low=0, tx_ready=1; a new 0xFF transfer then completes normally.
REQ-033 Pulse tx_valid during SHIFT with a different byte -> it is ignored; the original byte is transmitted, and exactly one tx_done occurs.
